bar_graph_drawer: RTL and testbench

- Parametrised rectangle/bar rasteriser for the VGA plotting path.
- Latches origin, size and colour on a start pulse, then walks every pixel of the rectangle in row-major order, one pixel per clock.
- Drives x/y/colour/plot to the VGA adapter and signals completion with a done pulse.
- Supports runtime bar width and height, off-screen clipping, and an erase mode that paints the background colour.

---
 rtl/bar_graph_drawer_if.sv | 31 +++
 rtl/bar_graph_drawer.sv | 121 ++++++++++++
 tb/tb_bar_graph_drawer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bar_graph_drawer_if.sv
// Request/pixel bus between a bar requester and the bar rasteriser.
interface bar_graph_drawer_if #(
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned COLOR_W = 3,
    parameter int unsigned DIM_W   = 6
);
    logic               start;
    logic               erase;
    logic [X_W-1:0]     start_x;
    logic [Y_W-1:0]     start_y;
    logic [DIM_W-1:0]   bar_w;
    logic [DIM_W-1:0]   bar_h;
    logic [COLOR_W-1:0] color_in;
    logic [X_W-1:0]     x_coord;
    logic [Y_W-1:0]     y_coord;
    logic [COLOR_W-1:0] color_out;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        output start, erase, start_x, start_y, bar_w, bar_h, color_in,
        input  x_coord, y_coord, color_out, plot, busy, done
    );

    modport slave (
        input  start, erase, start_x, start_y, bar_w, bar_h, color_in,
        output x_coord, y_coord, color_out, plot, busy, done
    );
endinterface

// File: rtl/bar_graph_drawer.sv
// Rectangle rasteriser: walks a latched bar row-major, one pixel per clock, clipping off-screen.
module bar_graph_drawer #(
    parameter int unsigned       X_W      = 10,
    parameter int unsigned       Y_W      = 9,
    parameter int unsigned       COLOR_W  = 3,
    parameter int unsigned       DIM_W    = 6,
    parameter int unsigned       SCREEN_W = 640,
    parameter int unsigned       SCREEN_H = 480,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    bar_graph_drawer_if.slave    bus
);

    localparam logic [X_W:0] XLim = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] YLim = (Y_W+1)'(SCREEN_H);

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

    state_e             state_q, state_d;
    logic [X_W-1:0]     x0_q, x0_d;
    logic [Y_W-1:0]     y0_q, y0_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [DIM_W-1:0]   off_x_q, off_x_d;
    logic [DIM_W-1:0]   off_y_q, off_y_d;

    logic               x_last, y_last;
    logic [X_W:0]       x_sum;
    logic [Y_W:0]       y_sum;

    assign x_last = (off_x_q == w_q - DIM_W'(1));
    assign y_last = (off_y_q == h_q - DIM_W'(1));
    // One extra bit so coordinates past the screen edge are not aliased back on-screen.
    assign x_sum  = {1'b0, x0_q} + (X_W+1)'(off_x_q);
    assign y_sum  = {1'b0, y0_q} + (Y_W+1)'(off_y_q);

    // State and datapath registers; reset aborts any bar in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            off_x_q <= '0;
            off_y_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
        end
    end

    // Next state and next datapath values; start is only honoured in idle.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    x0_d    = bus.start_x;
                    y0_d    = bus.start_y;
                    w_d     = bus.bar_w;
                    h_d     = bus.bar_h;
                    color_d = bus.erase ? BG_COLOR : bus.color_in;
                    off_x_d = '0;
                    off_y_d = '0;
                    state_d = (bus.bar_w == '0 || bus.bar_h == '0) ? StDone : StDraw;
                end
            end
            StDraw: begin
                if (x_last) begin
                    off_x_d = '0;
                    off_y_d = off_y_q + DIM_W'(1);
                    if (y_last) state_d = StDone;
                end else begin
                    off_x_d = off_x_q + DIM_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: pixel bus only live in draw, done only in the completion cycle.
    always_comb begin
        bus.x_coord   = '0;
        bus.y_coord   = '0;
        bus.color_out = '0;
        bus.plot      = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        unique case (state_q)
            StDraw: begin
                bus.x_coord   = x_sum[X_W-1:0];
                bus.y_coord   = y_sum[Y_W-1:0];
                bus.color_out = color_q;
                bus.plot      = (x_sum < XLim) && (y_sum < YLim);
                bus.busy      = 1'b1;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bar_graph_drawer.sv
// Scoreboard bench: stimulus pushes expected pixels/done, a negedge monitor pops and compares.
module tb_bar_graph_drawer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bar_graph_drawer_if bus ();

    bar_graph_drawer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        bit is_done;
        int x;
        int y;
        int color;
        int cyc;
        int nbusy;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   plot_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented pixel or done pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.plot || bus.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got plot=%0b done=%0b x=%0d y=%0d cyc=%0d, required no output",
                             bus.plot, bus.done, bus.x_coord, bus.y_coord, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        if (!bus.done || bus.plot || bus.busy || cyc != e.cyc || busy_cnt != e.nbusy) begin
                            errors++;
                            $display("FAIL done: got done=%0b plot=%0b busy=%0b cyc=%0d busy_cycles=%0d, required done=1 plot=0 busy=0 cyc=%0d busy_cycles=%0d",
                                     bus.done, bus.plot, bus.busy, cyc, busy_cnt, e.cyc, e.nbusy);
                        end
                    end else begin
                        if (!bus.plot || !bus.busy || bus.done || int'(bus.x_coord) != e.x ||
                            int'(bus.y_coord) != e.y || int'(bus.color_out) != e.color || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL pixel: got plot=%0b busy=%0b done=%0b (%0d,%0d) c=%0d cyc=%0d, required plot=1 busy=1 (%0d,%0d) c=%0d cyc=%0d",
                                     bus.plot, bus.busy, bus.done, bus.x_coord, bus.y_coord, bus.color_out, cyc,
                                     e.x, e.y, e.color, e.cyc);
                        end
                    end
                end
                if (bus.plot) plot_cnt++;
            end
            if (bus.done) busy_cnt = 0;
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (bus.x_coord != '0 || bus.y_coord != '0 || bus.color_out != '0 ||
            bus.plot || bus.busy || bus.done) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b, required all 0",
                     name, bus.x_coord, bus.y_coord, bus.color_out, bus.plot, bus.busy, bus.done);
        end
    endtask

    // Issue one start pulse; when push is set, queue the expected response.
    task automatic start_bar(input int sx, input int sy, input int w, input int h,
                             input int col, input bit er, input bit push);
        int cs;
        int k;
        @(posedge clk);
        #1;
        bus.start_x  = sx[9:0];
        bus.start_y  = sy[8:0];
        bus.bar_w    = w[5:0];
        bus.bar_h    = h[5:0];
        bus.color_in = col[2:0];
        bus.erase    = er;
        bus.start    = 1'b1;
        cs = cyc + 1;
        if (push) begin
            k = 0;
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    if (sx + c < 640 && sy + r < 480)
                        exp_q.push_back('{0, (sx + c) % 1024, (sy + r) % 512, er ? 0 : col, cs + k, 0});
                    k++;
                end
            end
            exp_q.push_back('{1, 0, 0, 0, cs + w * h, w * h});
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        // Scramble inputs: the bar in progress must not see these.
        bus.start_x  = 10'd5;
        bus.start_y  = 9'd7;
        bus.bar_w    = 6'd9;
        bus.bar_h    = 6'd9;
        bus.color_in = 3'd6;
        bus.erase    = ~er;
    endtask

    task automatic drain(input string name, input int exp_plots);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d outputs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (plot_cnt != exp_plots) begin
            errors++;
            $display("FAIL %s_plot_count: got %0d, required %0d", name, plot_cnt, exp_plots);
        end
        plot_cnt = 0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.erase    = 1'b0;
        bus.start_x  = '0;
        bus.start_y  = '0;
        bus.bar_w    = '0;
        bus.bar_h    = '0;
        bus.color_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic 4x4 bar.
        start_bar(100, 50, 4, 4, 2, 1'b0, 1'b1);
        drain("basic", 16);

        // Erase: same geometry, background colour.
        start_bar(100, 50, 4, 4, 7, 1'b1, 1'b1);
        drain("erase", 16);

        // Clipping at the bottom-right corner.
        start_bar(638, 478, 4, 3, 5, 1'b0, 1'b1);
        drain("clip", 4);

        // Zero-size bar: immediate done, no busy.
        start_bar(20, 20, 0, 5, 3, 1'b0, 1'b1);
        drain("zero", 0);

        // Start during draw is ignored.
        start_bar(10, 20, 3, 2, 5, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.start_x = 10'd300;
        bus.bar_w   = 6'd5;
        bus.bar_h   = 6'd5;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        drain("ignored_start", 6);

        // Reset mid-draw aborts with no done pulse.
        start_bar(100, 50, 4, 4, 2, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_zero("reset_mid_draw");
        exp_q.delete();
        plot_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        drain("post_reset_quiet", 0);

        // Next start after reset works normally.
        start_bar(200, 100, 2, 2, 4, 1'b0, 1'b1);
        drain("after_reset", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
